imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side counterpart to the instruction memory that the processor fetches from.
- Accepts a byte stream (valid/ready) carrying a word-count header followed by program bytes, assembles big-endian 32-bit words, and writes them sequentially into instruction memory.
- Holds the MIPS core in reset until the load completes, then releases it.
- Sits between a host or UART byte source and the `MIPS` top, driving the core reset and the instruction-memory write port.

Parameters:
- DEPTH, 256, instruction memory capacity in 32-bit words.
- ADDR_W, 32, width of the byte address driven to instruction memory.
- BASE_ADDR, 0, byte address of the first loaded word; must be word-aligned.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; restarts loading from DONE or ERR.
- s_data  input  8  stream byte.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  byte address of the write.
- imem_wdata  output  32  write data.
- core_reset  output  1  reset to the MIPS core; active-high.
- load_done  output  1  program loaded and core released.
- load_err  output  1  sticky error flag.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=LEN, s_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_reset=1, load_done=0, load_err=0. All internal counters and the byte shift register clear.
- A byte transfers when s_valid && s_ready are both high at a rising edge. s_ready is a registered function of state only: it is 1 in LEN, DATA and CSUM, and 0 in DONE and ERR. The loader never applies backpressure mid-word.

State machine:
- LEN:
  - Accepts 2 bytes forming a 16-bit word count N, most significant byte first.
  - After the second byte: if N==0, go to DONE. If N>DEPTH, go to ERR. Otherwise go to DATA with word index=0 and byte count=0.
- DATA:
  - Each accepted byte shifts into a 32-bit register; the first byte of a word lands in bits [31:24].
  - On the cycle after the 4th byte of a word is accepted, imem_we=1 for exactly one cycle, with imem_wdata set to the assembled word and imem_addr = BASE_ADDR + 4*index.
  - After that write, index increments. Index is a 16-bit counter with no wrap, because N<=DEPTH is enforced.
  - Once N words have been accepted: go to CSUM if the checksum feature is enabled, otherwise go to DONE.
  - The write for the last word completes in the same cycle the state advances.
- DONE:
  - core_reset=0 and load_done=1.
  - start=1 moves to LEN, reasserts core_reset=1 in the next cycle, clears load_done, and resets the index.
- ERR:
  - load_err=1, core_reset=1, s_ready=0.
  - start=1 moves to LEN and clears load_err.
- start is ignored in LEN, DATA and CSUM.
- Reset asserted mid-load abandons the partial word with no write issued. Words already written stay in memory. The loader returns to LEN.
- A byte offered while s_ready=0 is not consumed, and no state changes.
- s_valid held low mid-word stalls indefinitely with no timeout.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - A running XOR of every DATA byte is kept and cleared on entry to LEN.
  - The CSUM state accepts one byte.
  - If that byte equals the running XOR, go to DONE; otherwise go to ERR.
  - Memory contents already written are not rolled back.
- When undefined: no CSUM state and no XOR register; DATA goes straight to DONE.

Decomposition:
- Shared package mips_pkg holds:
  - the state encoding typedef: LEN, DATA, CSUM, DONE, ERR;
  - WORD_W=32;
  - BYTES_PER_WORD=4;
  - HDR_BYTES=2.
- One natural sub-module, byte_to_word_packer. It owns the 2-bit byte counter and the 32-bit shift register, and emits a one-cycle word_valid pulse with the assembled word. The FSM, address counter and core_reset control stay in imem_loader.

Test Plan:
- Zero length: stream 00 00 -> DONE one cycle later, core_reset=0, load_done=1, imem_we never asserted.
- Two words: stream 00 02 20 02 00 05 00 43 18 22 -> writes 0x20020005 at addr 0x0 and 0x00431822 at addr 0x4, each a single-cycle imem_we, then core_reset=0.
- Oversize: header 01 01 with DEPTH=256 -> ERR, load_err=1, s_ready=0, core_reset=1, no writes. A start pulse then clears load_err and returns to LEN.
- Stall and reset mid-word:
  - Gaps of 3 idle cycles between bytes -> identical writes to the unstalled case.
  - Reset after 2 of 4 data bytes -> no write issued, state=LEN, core_reset=1.
- Checksum (IMEM_LOADER_CHECKSUM_EN):
  - Header 00 01, data 11 22 33 44, checksum 44 -> DONE.
  - Same stream with checksum 45 -> ERR, and the word 0x11223344 remains written at addr 0x0.
- Reload: in DONE, pulse start and stream 00 01 AA BB CC DD -> core_reset rises the next cycle, 0xAABBCCDD is written at BASE_ADDR, then DONE again.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and
// stream framing constants.
package mips_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

  typedef enum logic [2:0] {
    ST_LEN  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Packs accepted stream bytes into big-endian words; pulses o_word_valid for
// one cycle after the last byte of each word, with the word held on o_word.
module byte_to_word_packer
  import mips_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [7:0]        i_byte,
  output logic              o_last,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_shift;
  logic              r_word_valid;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_next;

  // Earlier bytes move toward the MSB, so the first byte ends in [31:24].
  assign w_next       = {r_shift[WORD_W-9:0], i_byte};
  assign o_last       = (r_cnt == LP_LAST);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_valid) begin
        r_shift <= w_next;
        r_cnt   <= r_cnt + 1'b1;
        if (o_last) begin
          r_word_valid <= 1'b1;
          r_word       <= w_next;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory and holds the
// core in reset until loaded. Optional trailing checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import mips_pkg::*;
#(
  parameter int                 DEPTH     = 256,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err,
  output loader_state_t     dbg_state
);

  localparam int HDR_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam logic [HDR_W-1:0] LP_HDR_LAST = HDR_W'(HDR_BYTES - 1);
  localparam logic [16:0]      LP_DEPTH    = 17'(DEPTH);

  loader_state_t     r_state;
  logic              r_s_ready;
  logic              r_core_reset;
  logic              r_load_done;
  logic              r_load_err;
  logic [HDR_W-1:0]  r_hdr_cnt;
  logic [15:0]       r_len;
  logic [15:0]       r_index;
  logic [ADDR_W-1:0] r_addr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_xor;
`endif

  logic              w_acc;
  logic              w_acc_data;
  logic              w_last_byte;
  logic              w_word_valid;
  logic [WORD_W-1:0] w_word;
  logic [15:0]       w_len_next;

  assign w_acc      = s_valid && r_s_ready;
  assign w_acc_data = w_acc && (r_state == ST_DATA);
  assign w_len_next = {r_len[7:0], s_data};

  byte_to_word_packer u_packer (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_valid      (w_acc_data),
    .i_byte       (s_data),
    .o_last       (w_last_byte),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  assign s_ready    = r_s_ready;
  assign imem_we    = w_word_valid;
  assign imem_wdata = w_word;
  assign imem_addr  = r_addr;
  assign core_reset = r_core_reset;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_LEN;
      r_s_ready    <= 1'b1;
      r_core_reset <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_hdr_cnt    <= '0;
      r_len        <= '0;
      r_index      <= '0;
      r_addr       <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor        <= '0;
`endif
    end else begin
      // The address register already points at the word being written.
      if (w_word_valid) begin
        r_index <= r_index + 16'd1;
        r_addr  <= r_addr + ADDR_W'(4);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_acc_data) r_xor <= r_xor ^ s_data;
`endif
      case (r_state)
        ST_LEN: begin
          if (w_acc) begin
            r_len <= w_len_next;
            if (r_hdr_cnt == LP_HDR_LAST) begin
              r_hdr_cnt <= '0;
              if (w_len_next == 16'd0) begin
                r_state      <= ST_DONE;
                r_s_ready    <= 1'b0;
                r_core_reset <= 1'b0;
                r_load_done  <= 1'b1;
              end else if ({1'b0, w_len_next} > LP_DEPTH) begin
                r_state    <= ST_ERR;
                r_s_ready  <= 1'b0;
                r_load_err <= 1'b1;
              end else begin
                r_state <= ST_DATA;
                r_index <= '0;
                r_addr  <= BASE_ADDR;
              end
            end else begin
              r_hdr_cnt <= r_hdr_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          // Leave on the last byte; its write lands in the first cycle of the next state.
          if (w_acc && w_last_byte && (r_index == r_len - 16'd1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state <= ST_CSUM;
`else
            r_state      <= ST_DONE;
            r_s_ready    <= 1'b0;
            r_core_reset <= 1'b0;
            r_load_done  <= 1'b1;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (w_acc) begin
            r_s_ready <= 1'b0;
            if (s_data == r_xor) begin
              r_state      <= ST_DONE;
              r_core_reset <= 1'b0;
              r_load_done  <= 1'b1;
            end else begin
              r_state    <= ST_ERR;
              r_load_err <= 1'b1;
            end
          end
        end
`endif
        ST_DONE: begin
          if (start) begin
            r_state      <= ST_LEN;
            r_s_ready    <= 1'b1;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_index      <= '0;
            r_addr       <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor        <= '0;
`endif
          end
        end
        ST_ERR: begin
          if (start) begin
            r_state    <= ST_LEN;
            r_s_ready  <= 1'b1;
            r_load_err <= 1'b0;
            r_index    <= '0;
            r_addr     <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
          end
        end
        default: begin
          r_state   <= ST_LEN;
          r_s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random loads checked against a
// stream-level model of expected writes and final load status.
module tb_imem_loader;
  import mips_pkg::*;

  localparam int          DEPTH  = 256;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              load_done;
  logic              load_err;
  loader_state_t     dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          poke_start = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] words_q[$];
  logic [63:0] mon_e;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the next expected {addr, data}
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'(imem_we), 64'(1'b0));
      end else begin
        mon_e = exp_q.pop_front();
        check("imem_addr", 64'(imem_addr), {32'h0, mon_e[63:32]});
        check("imem_wdata", 64'(imem_wdata), {32'h0, mon_e[31:0]});
      end
    end
  end

  task automatic check_status(input string tag, input loader_state_t st);
    bit done_e;
    bit err_e;
    done_e = (st == ST_DONE);
    err_e  = (st == ST_ERR);
    check({tag, "_state"},      64'(dbg_state),  64'(st));
    check({tag, "_load_done"},  64'(load_done),  64'(done_e));
    check({tag, "_load_err"},   64'(load_err),   64'(err_e));
    check({tag, "_core_reset"}, 64'(core_reset), 64'(!done_e));
    check({tag, "_s_ready"},    64'(s_ready),    64'(!(done_e || err_e)));
  endtask

  // driver: optional idle gap (with ignored start pokes), then one byte
  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax);
    int g;
    int t;
    g = int'($urandom_range(gmax, gmin));
    repeat (g) begin
      start = poke_start && ($urandom_range(7, 0) == 0);
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check("s_ready_wait", 64'(s_ready), 64'(1'b1));
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_status(tag, ST_LEN);
  endtask

  task automatic fill_random(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom);
  endtask

  // reference model: header N, N big-endian words, optional XOR byte
  task automatic run_load(input string tag, input int n, input int gmin, input int gmax,
                          input bit bad_cs);
    logic [7:0]  cs;
    logic [31:0] w;
    bit          exp_err;
    cs      = 8'h00;
    exp_err = (n > DEPTH);
    send_byte(8'(n >> 8), gmin, gmax);
    send_byte(8'(n), gmin, gmax);
    if (n != 0 && !exp_err) begin
      for (int i = 0; i < n; i++) begin
        w = words_q[i];
        exp_q.push_back({BASE + 32'(4 * i), w});
        for (int k = 3; k >= 0; k--) begin
          cs = cs ^ w[8*k +: 8];
          send_byte(w[8*k +: 8], gmin, gmax);
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_err = bad_cs;
      send_byte(bad_cs ? (cs ^ 8'h01) : cs, gmin, gmax);
`else
      if (bad_cs) exp_err = 1'b0;
`endif
    end
    check_status(tag, exp_err ? ST_ERR : ST_DONE);
    repeat (2) @(negedge clk);
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int r;
    int n;
    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_s_ready",    64'(s_ready),    64'(1'b1));
    check("rst_imem_we",    64'(imem_we),    64'(1'b0));
    check("rst_imem_addr",  64'(imem_addr),  64'(BASE));
    check("rst_imem_wdata", 64'(imem_wdata), 64'(0));
    check("rst_core_reset", 64'(core_reset), 64'(1'b1));
    check("rst_load_done",  64'(load_done),  64'(1'b0));
    check("rst_load_err",   64'(load_err),   64'(1'b0));
    check("rst_state",      64'(dbg_state),  64'(ST_LEN));
    reset = 1'b0;
    @(negedge clk);
    check_status("idle", ST_LEN);

    // zero length header
    run_load("zero", 0, 0, 0, 1'b0);
    pulse_start("zero_restart");

    // two-word program, back to back then with 3-cycle gaps
    words_q.delete();
    words_q.push_back(32'h20020005);
    words_q.push_back(32'h00431822);
    run_load("two", 2, 0, 0, 1'b0);
    pulse_start("two_restart");
    run_load("stall", 2, 3, 3, 1'b0);
    pulse_start("stall_restart");

    // oversize header, bytes offered while not ready are ignored
    run_load("over", 257, 0, 0, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    check_status("over_hold", ST_ERR);
    pulse_start("over_restart");

    // largest legal program
    fill_random(DEPTH);
    run_load("full", DEPTH, 0, 1, 1'b0);
    pulse_start("full_restart");

    // reset after half a word: nothing written, back in LEN
    send_byte(8'h00, 0, 0);
    send_byte(8'h01, 0, 0);
    send_byte(8'h11, 0, 0);
    send_byte(8'h22, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_status("midrst", ST_LEN);
    check("midrst_writes", 64'(exp_q.size()), 64'(0));

`ifdef IMEM_LOADER_CHECKSUM_EN
    words_q.delete();
    words_q.push_back(32'h11223344);
    run_load("cs_good", 1, 0, 0, 1'b0);
    pulse_start("cs_good_restart");
    run_load("cs_bad", 1, 0, 0, 1'b1);
    pulse_start("cs_bad_restart");
`endif

    // reload from DONE
    fill_random(3);
    run_load("pre_reload", 3, 0, 2, 1'b0);
    pulse_start("reload_start");
    words_q.delete();
    words_q.push_back(32'hAABBCCDD);
    run_load("reload", 1, 0, 0, 1'b0);
    pulse_start("reload_restart");

    // random loads with random gaps and ignored start pulses
    poke_start = 1'b1;
    for (int it = 0; it < 20; it++) begin
      r = int'($urandom_range(9, 0));
      if (r == 0)      n = 0;
      else if (r == 1) n = int'($urandom_range(65535, DEPTH + 1));
      else             n = int'($urandom_range(8, 1));
      fill_random(n > DEPTH ? 0 : n);
      run_load("rand", n, 0, 3, ($urandom_range(3, 0) == 0));
      pulse_start("rand_restart");
    end
    poke_start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
